// File: rtl/pipe_pkg.sv
// Shared types and sizing helpers for the pipe_vr valid/ready pipeline.
package pipe_pkg;

    typedef enum logic [1:0] {SK_EMPTY, SK_ONE, SK_TWO} skid_state_t;
    typedef enum logic {RG_EMPTY, RG_FULL} reg_state_t;

    // Occupancy counter width: holds 0..slots*depth inclusive.
    function automatic int count_width(input int depth, input int reg_ready);
        return $clog2(((reg_ready != 0) ? 2 : 1) * depth + 1);
    endfunction

endpackage

// File: rtl/pipe_vr_slice.sv
// One pipeline stage: either a 2-entry skid buffer with registered ready,
// or a single register with combinational ready pass-through.
module pipe_vr_slice
    import pipe_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int REG_READY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_valid,
    output logic             up_ready,
    output logic [WIDTH-1:0] dn_data,
    output logic             dn_valid,
    input  logic             dn_ready
);

    logic up_xfer;
    logic dn_xfer;

    assign up_xfer = up_valid & up_ready;
    assign dn_xfer = dn_valid & dn_ready;

    if (REG_READY != 0) begin : g_skid
        skid_state_t      state;
        skid_state_t      state_nxt;
        logic [WIDTH-1:0] main_p0;
        logic [WIDTH-1:0] skid_p0;
        logic             ready_q;

        always_comb begin
            state_nxt = state;
            case (state)
                SK_EMPTY: if (up_xfer) state_nxt = SK_ONE;
                SK_ONE: begin
                    if (up_xfer && !dn_xfer)      state_nxt = SK_TWO;
                    else if (!up_xfer && dn_xfer) state_nxt = SK_EMPTY;
                end
                SK_TWO:   if (dn_xfer) state_nxt = SK_ONE;
                default:  state_nxt = SK_EMPTY;
            endcase
        end

        // Ready is a flop computed from the next state, so it never sees dn_ready combinationally.
        always_ff @(posedge clk) begin
            if (reset) begin
                state   <= SK_EMPTY;
                ready_q <= 1'b1;
            end else begin
                state   <= state_nxt;
                ready_q <= (state_nxt != SK_TWO);
            end
        end

        always_ff @(posedge clk) begin
            case (state)
                SK_EMPTY: if (up_xfer) main_p0 <= up_data;
                SK_ONE: begin
                    if (up_xfer && dn_xfer) main_p0 <= up_data;
                    else if (up_xfer)       skid_p0 <= up_data;
                end
                SK_TWO:   if (dn_xfer) main_p0 <= skid_p0;
                default: ;
            endcase
        end

        assign up_ready = ready_q;
        assign dn_valid = (state != SK_EMPTY);
        assign dn_data  = main_p0;
    end else begin : g_simple
        reg_state_t       state;
        logic [WIDTH-1:0] data_p0;

        always_ff @(posedge clk) begin
            if (reset)        state <= RG_EMPTY;
            else if (up_xfer) state <= RG_FULL;
            else if (dn_xfer) state <= RG_EMPTY;
        end

        always_ff @(posedge clk) begin
            if (up_xfer) data_p0 <= up_data;
        end

        assign up_ready = (state == RG_EMPTY) | dn_ready;
        assign dn_valid = (state == RG_FULL);
        assign dn_data  = data_p0;
    end

endmodule

// File: rtl/pipe_vr.sv
// Parametrised valid/ready pipeline: DEPTH slices in series plus an occupancy counter.
module pipe_vr
    import pipe_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 2,
    parameter  int REG_READY = 1,
    localparam int CW        = count_width(DEPTH, REG_READY)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [CW-1:0]    count
);

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] up_data;
        logic             up_valid;
        logic             up_ready;
        logic [WIDTH-1:0] dn_data;
        logic             dn_valid;
        logic             dn_ready;

        if (k == 0) begin : g_head
            assign up_data  = i_data;
            assign up_valid = i_valid;
        end else begin : g_link
            assign up_data  = g_stage[k-1].dn_data;
            assign up_valid = g_stage[k-1].dn_valid;
        end

        if (k == DEPTH - 1) begin : g_tail
            assign dn_ready = o_ready;
        end else begin : g_next
            assign dn_ready = g_stage[k+1].up_ready;
        end

        pipe_vr_slice #(
            .WIDTH    (WIDTH),
            .REG_READY(REG_READY)
        ) u_slice (
            .clk     (clk),
            .reset   (reset),
            .up_data (up_data),
            .up_valid(up_valid),
            .up_ready(up_ready),
            .dn_data (dn_data),
            .dn_valid(dn_valid),
            .dn_ready(dn_ready)
        );
    end

    assign i_ready = g_stage[0].up_ready;
    assign o_data  = g_stage[DEPTH-1].dn_data;
    assign o_valid = g_stage[DEPTH-1].dn_valid;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = i_valid & i_ready;
    assign out_xfer = o_valid & o_ready;

    // Occupancy tracked by its own up/down counter rather than summing slice states.
    always_ff @(posedge clk) begin
        if (reset)                     count <= '0;
        else if (in_xfer && !out_xfer) count <= count + CW'(1);
        else if (!in_xfer && out_xfer) count <= count - CW'(1);
    end

endmodule
